// File: rtl/kbd_matrix_scan_if.sv
// Ordered key-event stream from the matrix scanner to the keyboard mapper.
interface kbd_matrix_scan_if;
   logic [6:0] scancode;
   logic       trigger;
   logic       pressed;
   logic       scan_done;

   modport master (output scancode, trigger, pressed, scan_done);
   modport slave  (input  scancode, trigger, pressed, scan_done);
endinterface

// File: rtl/kbd_matrix_scan.sv
// Keyboard matrix scanner: one-hot row drive, synchronized column capture, per-key state, ordered events.
// Define KBD_MATRIX_DEBOUNCE_EN for multi-scan debounce; when undefined each key follows its latest sample.
module kbd_matrix_scan #(
   parameter int NUM_ROWS       = 8,
   parameter int NUM_COLS       = 10,
   parameter int SETTLE_CYCLES  = 16,
   parameter int SCAN_GAP       = 64,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                scan_enable,
   input  logic [NUM_COLS-1:0] col_in,
   output logic [NUM_ROWS-1:0] row_oe,
   kbd_matrix_scan_if.master   evt
);
   localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;
   localparam int KEY_W    = $clog2(NUM_KEYS);
   localparam int ROW_W    = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
   localparam int COL_W    = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
   localparam int SET_W    = $clog2(SETTLE_CYCLES);
   localparam int GAP_W    = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
   localparam logic [NUM_ROWS-1:0] ROW_ONE = NUM_ROWS'(1);

   generate
      if (NUM_KEYS > 128 || SETTLE_CYCLES < 3 || DEBOUNCE_SCANS < 1) begin : g_bad_params
         $error("kbd_matrix_scan: invalid parameter set");
      end
   endgenerate

   typedef enum logic [1:0] {ST_GAP, ST_DRIVE, ST_EMIT} state_t;

   state_t              state_reg;
   logic [NUM_COLS-1:0] col_meta_reg, col_sync_reg, col_latch_reg;
   logic [ROW_W-1:0]    row_reg;
   logic [COL_W-1:0]    col_reg;
   logic [KEY_W-1:0]    key_reg;
   logic [SET_W-1:0]    settle_reg;
   logic [GAP_W-1:0]    gap_reg;
   logic                done_pend_reg;
   logic [NUM_ROWS-1:0] row_oe_reg;
   logic [6:0]          scancode_reg;
   logic                trigger_reg, pressed_reg, scan_done_reg;

   logic [NUM_KEYS-1:0] stable_vec;
   logic                raw_bit, cur_state, flip, next_state, key_hit;

   always_ff @(posedge clk) begin
      if (reset) begin
         col_meta_reg <= '0;
         col_sync_reg <= '0;
      end else begin
         col_meta_reg <= col_in;
         col_sync_reg <= col_meta_reg;
      end
   end

   assign key_hit    = (state_reg == ST_EMIT);
   assign raw_bit    = col_latch_reg[col_reg];
   assign cur_state  = stable_vec[key_reg];
   // pressed always reports the key's state after this scan's update
   assign next_state = flip ? raw_bit : cur_state;

`ifdef KBD_MATRIX_DEBOUNCE_EN
   localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
   logic [CNT_W-1:0] cnt_vec [NUM_KEYS];
   logic [CNT_W-1:0] cur_cnt, cnt_next;

   assign cur_cnt  = cnt_vec[key_reg];
   assign flip     = (raw_bit != cur_state) && (cur_cnt == CNT_W'(DEBOUNCE_SCANS - 1));
   // counts only while disagreeing and below threshold, so it never wraps
   assign cnt_next = ((raw_bit != cur_state) && !flip) ? cur_cnt + CNT_W'(1) : '0;
`else
   assign flip = (raw_bit != cur_state);
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_KEYS; gi++) begin : g_key
         logic stable_reg;
         always_ff @(posedge clk) begin
            if (reset)
               stable_reg <= 1'b0;
            else if (key_hit && key_reg == KEY_W'(gi))
               stable_reg <= next_state;
         end
         assign stable_vec[gi] = stable_reg;
`ifdef KBD_MATRIX_DEBOUNCE_EN
         logic [CNT_W-1:0] cnt_reg;
         always_ff @(posedge clk) begin
            if (reset)
               cnt_reg <= '0;
            else if (key_hit && key_reg == KEY_W'(gi))
               cnt_reg <= cnt_next;
         end
         assign cnt_vec[gi] = cnt_reg;
`endif
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_GAP;
         gap_reg       <= '0;
         settle_reg    <= '0;
         row_reg       <= '0;
         col_reg       <= '0;
         key_reg       <= '0;
         col_latch_reg <= '0;
         done_pend_reg <= 1'b0;
         row_oe_reg    <= '0;
         trigger_reg   <= 1'b0;
         scancode_reg  <= '0;
         pressed_reg   <= 1'b0;
         scan_done_reg <= 1'b0;
      end else begin
         row_oe_reg    <= '0;
         trigger_reg   <= 1'b0;
         scan_done_reg <= done_pend_reg;
         done_pend_reg <= 1'b0;
         case (state_reg)
            ST_GAP: begin
               if (gap_reg != '0) begin
                  gap_reg <= gap_reg - GAP_W'(1);
               end else if (scan_enable) begin
                  state_reg  <= ST_DRIVE;
                  row_reg    <= '0;
                  key_reg    <= '0;
                  settle_reg <= '0;
               end
            end
            ST_DRIVE: begin
               row_oe_reg <= ROW_ONE << row_reg;
               settle_reg <= settle_reg + SET_W'(1);
               if (settle_reg == SET_W'(SETTLE_CYCLES - 1)) begin
                  col_latch_reg <= ~col_sync_reg;
                  col_reg       <= '0;
                  state_reg     <= ST_EMIT;
               end
            end
            ST_EMIT: begin
               trigger_reg  <= 1'b1;
               scancode_reg <= 7'(key_reg);
               pressed_reg  <= next_state;
               key_reg      <= key_reg + KEY_W'(1);
               col_reg      <= col_reg + COL_W'(1);
               if (col_reg == COL_W'(NUM_COLS - 1)) begin
                  if (row_reg == ROW_W'(NUM_ROWS - 1)) begin
                     state_reg     <= ST_GAP;
                     gap_reg       <= GAP_W'(SCAN_GAP - 1);
                     key_reg       <= '0;
                     done_pend_reg <= 1'b1;
                  end else begin
                     row_reg    <= row_reg + ROW_W'(1);
                     settle_reg <= '0;
                     state_reg  <= ST_DRIVE;
                  end
               end
            end
            default: state_reg <= ST_GAP;
         endcase
      end
   end

   assign row_oe        = row_oe_reg;
   assign evt.scancode  = scancode_reg;
   assign evt.trigger   = trigger_reg;
   assign evt.pressed   = pressed_reg;
   assign evt.scan_done = scan_done_reg;
endmodule

// File: tb/tb_kbd_matrix_scan.sv
// Bench for kbd_matrix_scan: timeline/debounce model from scan start times, random key patterns, literal pins.
`timescale 1ns/1ps
module tb_kbd_matrix_scan;
   localparam int NR = 8, NC = 10, NK = 80, SETTLE = 16, ROWP = SETTLE + NC, PERIOD = 272;
`ifdef KBD_MATRIX_DEBOUNCE_EN
   localparam int DB = 3;
   localparam bit [5:0] P23_EXP = 6'b100000;
   localparam bit [2:0] P7_EXP  = 3'b100;
`else
   localparam int DB = 1;
   localparam bit [5:0] P23_EXP = 6'b111010;
   localparam bit [2:0] P7_EXP  = 3'b111;
`endif

   logic          clk = 1'b0, reset = 1'b1, scan_enable = 1'b0;
   logic [NC-1:0] col_in;
   logic [NR-1:0] row_oe;
   bit            phys [NK];

   kbd_matrix_scan_if evt ();

   kbd_matrix_scan dut (
      .clk(clk), .reset(reset), .scan_enable(scan_enable),
      .col_in(col_in), .row_oe(row_oe), .evt(evt)
   );

   always #5 clk = ~clk;

   // physical matrix: a closed key pulls its column low while its row is driven
   always_comb begin
      col_in = '1;
      for (int c = 0; c < NC; c++)
         for (int r = 0; r < NR; r++)
            if (row_oe[r] && phys[r*NC+c]) col_in[c] = 1'b0;
   end

   int errors = 0, checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // model state: scan start edge, per-key stable state and disagreement count
   int       cyc = 0, s_edge = 0, ready_at = 1 << 30;
   bit       scanning = 0;
   bit       m_stable [NK];
   int       m_cnt [NK];
   int       m_o, m_r, m_m, m_k;
   bit       m_raw;
   bit       exp_trig, exp_done, exp_rst, exp_pr;
   logic [NR-1:0] exp_oe;
   int       exp_code;

   // observed per-scan results
   int n_scans = 0, cur_trig = 0, cur_pcnt = 0, cur_pcode = -1;
   int done_trig [64], pcnt [64], pcode [64], first_trig [64];
   bit p23 [64], p7 [64];

   always @(posedge clk) begin
      cyc++;
      exp_trig = 0; exp_done = 0; exp_rst = 0; exp_oe = '0;
      if (reset) begin
         scanning = 0; ready_at = cyc + 1; exp_rst = 1; exp_code = 0; exp_pr = 0;
         for (int k = 0; k < NK; k++) begin m_stable[k] = 0; m_cnt[k] = 0; end
      end else begin
         if (!scanning && cyc >= ready_at && scan_enable) begin
            scanning = 1; s_edge = cyc;
         end
         if (scanning) begin
            m_o = cyc - s_edge;
            if (m_o >= 1 && m_o <= NR*ROWP) begin
               m_r = (m_o - 1) / ROWP;
               m_m = (m_o - 1) % ROWP;
               if (m_m < SETTLE) exp_oe = NR'(1) << m_r;
               else begin
                  exp_trig = 1;
                  m_k = m_r*NC + m_m - SETTLE;
                  exp_code = m_k;
                  m_raw = phys[m_k];
                  if (m_raw == m_stable[m_k]) begin
                     m_cnt[m_k] = 0; exp_pr = m_raw;
                  end else if (m_cnt[m_k] == DB - 1) begin
                     m_stable[m_k] = m_raw; m_cnt[m_k] = 0; exp_pr = m_raw;
                  end else begin
                     m_cnt[m_k]++; exp_pr = m_stable[m_k];
                  end
               end
            end else if (m_o == NR*ROWP + 1) begin
               exp_done = 1; scanning = 0; ready_at = s_edge + PERIOD;
            end
         end
      end
      #1;
      chk("trigger", int'(evt.trigger), int'(exp_trig));
      chk("scan_done", int'(evt.scan_done), int'(exp_done));
      chk("row_oe", int'(row_oe), int'(exp_oe));
      if (exp_trig || exp_rst) begin
         chk("scancode", int'(evt.scancode), exp_code);
         chk("pressed", int'(evt.pressed), int'(exp_pr));
      end
      if (reset) begin
         cur_trig = 0; cur_pcnt = 0; cur_pcode = -1;
      end
      if (evt.trigger && n_scans < 64) begin
         cur_trig++;
         if (evt.scancode == 7'd0)  first_trig[n_scans] = cyc;
         if (evt.scancode == 7'd23) p23[n_scans] = evt.pressed;
         if (evt.scancode == 7'd7)  p7[n_scans]  = evt.pressed;
         if (evt.pressed) begin cur_pcnt++; cur_pcode = int'(evt.scancode); end
      end
      if (evt.scan_done && n_scans < 64) begin
         done_trig[n_scans] = cur_trig; pcnt[n_scans] = cur_pcnt; pcode[n_scans] = cur_pcode;
         $display("scan %0d done: triggers=%0d pressed_keys=%0d", n_scans, cur_trig, cur_pcnt);
         n_scans++;
         cur_trig = 0; cur_pcnt = 0; cur_pcode = -1;
      end
   end

   task automatic wait_scans(input int target);
      int n = 0;
      while (n_scans < target && n < 10*PERIOD) begin @(negedge clk); n++; end
      chk("scan_count", n_scans, target);
   endtask

   task automatic wait_code(input int code);
      int n = 0;
      while (!(evt.trigger && int'(evt.scancode) == code) && n < 2*PERIOD) begin
         @(negedge clk); n++;
      end
      chk("wait_scancode", int'(evt.trigger && int'(evt.scancode) == code), 1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      bit [5:0] p23_exp;
      bit [2:0] p7_exp;
      int base;
      p23_exp = P23_EXP;
      p7_exp  = P7_EXP;
      for (int k = 0; k < NK; k++) phys[k] = 0;
      reset = 1;
      repeat (4) @(negedge clk);
      chk("rst_row_oe", int'(row_oe), 0);
      chk("rst_trigger", int'(evt.trigger), 0);
      chk("rst_scancode", int'(evt.scancode), 0);
      chk("rst_pressed", int'(evt.pressed), 0);
      chk("rst_scan_done", int'(evt.scan_done), 0);
      reset = 0; scan_enable = 1;

      // scan 0 empty, scan 1 single-scan glitch on key 23, scan 2 open, scans 3..5 held
      wait_scans(1);
      chk("scan0_triggers", done_trig[0], 80);
      chk("scan0_pressed", pcnt[0], 0);
      phys[23] = 1;
      wait_scans(2);
      chk("first_trig_spacing", first_trig[1] - first_trig[0], PERIOD);
      phys[23] = 0;
      wait_scans(3);
      phys[23] = 1;
      wait_scans(6);
      for (int i = 0; i < 6; i++) chk($sformatf("key23_scan%0d", i), int'(p23[i]), int'(p23_exp[i]));

      // release 23, close row 4 col 4: by scan 8 only key 44 is down
      phys[23] = 0; phys[44] = 1;
      wait_scans(9);
      chk("scan8_pressed_count", pcnt[8], 1);
      chk("scan8_pressed_code", pcode[8], 44);
      phys[44] = 0;

      // random key patterns, checked cycle by cycle against the model
      for (int s = 0; s < 6; s++) begin
         for (int i = 0; i < 6; i++) begin
            int k;
            k = int'($urandom_range(NK - 1, 0));
            phys[k] = !phys[k];
         end
         wait_scans(n_scans + 1);
      end
      for (int k = 0; k < NK; k++) phys[k] = 0;

      // drop scan_enable at key 37: scan completes, then idle until re-enabled
      wait_code(37);
      scan_enable = 0;
      base = n_scans;
      wait_scans(base + 1);
      chk("drop_scan_triggers", done_trig[base], 80);
      repeat (600) @(negedge clk);
      chk("idle_no_scan", n_scans, base + 1);
      scan_enable = 1;
      wait_scans(base + 2);
      chk("resume_scan_triggers", done_trig[base + 1], 80);

      // debounce key 7 down, then reset mid-scan at key 55
      phys[7] = 1;
      base = n_scans;
      wait_scans(base + 3);
      chk("key7_before_reset", int'(p7[base + 2]), 1);
      wait_code(55);
      reset = 1;
      repeat (2) @(negedge clk);
      chk("midrst_trigger", int'(evt.trigger), 0);
      chk("midrst_row_oe", int'(row_oe), 0);
      reset = 0;
      base = n_scans;
      wait_scans(base + 3);
      chk("post_reset_triggers", done_trig[base], 80);
      for (int i = 0; i < 3; i++) chk($sformatf("key7_after_reset%0d", i), int'(p7[base + i]), int'(p7_exp[i]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/kbd_matrix_scan.md
Name: kbd_matrix_scan

Overview:
- Scans the physical 8x10 keyboard matrix by driving one row at a time and sampling the 10 active-low column inputs.
- Debounces each of the 80 keys and emits one event per key per scan as a strictly ordered stream: scancode 0..NUM_ROWS*NUM_COLS-1, with trigger and pressed.
- The stream feeds the downstream keyboard mapper. That mapper relies on every key index appearing exactly once per scan, in order, so it can compare each key against its previous-scan state.

Parameters:
- NUM_ROWS, 8, matrix rows driven.
- NUM_COLS, 10, matrix columns sampled; NUM_ROWS*NUM_COLS must be <=128.
- SETTLE_CYCLES, 16, cycles a row is driven before columns are captured; must be >=3.
- SCAN_GAP, 64, idle cycles between the end of one scan and the start of the next.
- DEBOUNCE_SCANS, 3, consecutive disagreeing scans needed to flip a key's stable state; must be >=1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- scan_enable  in  1  when high, scans run back-to-back; when low, idle after the current scan completes.
- col_in  in  NUM_COLS  asynchronous column lines, active-low (low = key closed on driven row).
- row_oe  out  NUM_ROWS  one-hot row drive enable; the top level drives the row low where set, otherwise high-Z.
- scancode  out  7  key index = row*NUM_COLS+col.
- trigger  out  1  one-cycle strobe; scancode/pressed are valid in the same cycle.
- pressed  out  1  debounced key state after this scan's update.
- scan_done  out  1  one-cycle pulse on the cycle after the last key's trigger.

Behaviour:
- Reset: clk, reset as decided (reset synchronous, active-high; clock clk). row_oe=0, trigger=0, scancode=0, pressed=0, scan_done=0. All stable states = released, all debounce counters = 0. Synchronizer cleared. FSM goes to GAP with gap counter=0, so the first scan starts the cycle after reset deasserts if scan_enable=1.
- Reset mid-scan aborts the scan. The next scan restarts at key 0, and no partial-scan events are emitted after reset.
- col_in passes through a 2-flop synchronizer. raw = ~col_sync.
- FSM states:
  - GAP: row_oe=0. Counts SCAN_GAP cycles. Leaves to DRIVE(row 0) only when the count is done and scan_enable=1; otherwise holds.
  - DRIVE: row_oe=1<<row for exactly SETTLE_CYCLES cycles. On the last DRIVE cycle, raw columns are captured into col_latch. Then go to EMIT with col=0.
  - EMIT: row_oe=0. Lasts NUM_COLS cycles; one key is processed per cycle and trigger=1 is registered for each. After col=NUM_COLS-1: if row<NUM_ROWS-1, go to DRIVE(row+1); otherwise go to GAP and pulse scan_done the following cycle.
- Triggers within a row are on consecutive cycles. Total scan period = NUM_ROWS*(SETTLE_CYCLES+NUM_COLS)+SCAN_GAP = 272 cycles at defaults.
- Per-key debounce for key k in EMIT, with r=col_latch[col] and s=stable[k]:
  - r==s: cnt<=0; pressed<=s.
  - r!=s and cnt==DEBOUNCE_SCANS-1: stable<=r; cnt<=0; pressed<=r.
  - Otherwise: cnt<=cnt+1; pressed<=s.
  - Counter width = clog2(DEBOUNCE_SCANS) with a minimum of 1; the counter never wraps.
- scan_enable is sampled only in GAP. Dropping it mid-scan never truncates a scan.
- Glitch on a single scan (r!=s once, then r==s): counter clears and the state never flips.

Optional Feature:
- Macro KBD_MATRIX_DEBOUNCE_EN.
- Defined: debounce exactly as above.
- Undefined: counters and DEBOUNCE_SCANS logic are removed. pressed = r directly, and stable[k] tracks r every scan. Scan timing and ordering are unchanged.

Test Plan:
- Reset then scan_enable=1, no keys: exactly 80 triggers, scancode 0..79 ascending, all pressed=0. scan_done asserts once. The next scan's first trigger is 272 cycles after the previous scan's first trigger.
- Hold row 2 / col 3 closed from scan 0: scancode 23 reports pressed=0 on scans 0 and 1, then pressed=1 from scan 2 onward; all other keys stay 0. With KBD_MATRIX_DEBOUNCE_EN undefined, pressed=1 from scan 0.
- Key 23 closed for a single scan only: scancode 23 stays pressed=0 throughout and its counter returns to 0.
- Check the row_oe pattern: each row one-hot for 16 cycles, never two bits set, and 0 during EMIT and GAP. A column closed on row 4 is reported only at scancodes 40..49.
- Deassert scan_enable at key 37 of a scan: keys 38..79 are still emitted, then no triggers. Reassert: the next scan starts at scancode 0.
- Assert reset at scancode 55 with key 7 debounced-pressed: no further triggers until after reset, the next scan starts at 0, and key 7 reads 0 for two scans before returning to 1.
